// File: rtl/fx3_out_path.sv
// FX3 slave-FIFO out path: drains one PPFIFO read block into FX3 DMA buffers,
// one buffer per controller grant, committing short final bursts with pkt_end.
module fx3_out_path #(
    parameter int DMA_BUF_WORDS = 512,
    parameter int SIZE_WIDTH    = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_out_path_ready,
    input  logic                  i_out_path_enable,
    output logic                  o_out_path_busy,
    output logic                  o_out_path_finished,
    input  logic                  i_out_dma_buf_ready,
    output logic                  o_out_dma_buf_finished,
    input  logic                  i_rd_rdy,
    output logic                  o_rd_act,
    input  logic [SIZE_WIDTH-1:0] i_rd_size,
    output logic                  o_rd_stb,
    input  logic [31:0]           i_rd_data,
    output logic [31:0]           o_fx3_data,
    output logic                  o_fx3_wr,
    output logic                  o_fx3_pkt_end
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACTIVATE = 3'd1;
    localparam logic [2:0] S_WAIT_BUF = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_BUF_DONE = 3'd4;
    localparam logic [2:0] S_FINISH   = 3'd5;

    localparam logic [SIZE_WIDTH-1:0] BUF_W = SIZE_WIDTH'(DMA_BUF_WORDS);
    localparam logic [SIZE_WIDTH-1:0] ONE   = SIZE_WIDTH'(1);

    logic [2:0]            r_state;
    logic [SIZE_WIDTH-1:0] r_remain;
    logic [SIZE_WIDTH-1:0] r_burst;
    logic                  r_short;
    logic                  r_rd_act;
    logic                  r_busy;
    logic                  r_finished;
    logic                  r_buf_fin;
    logic [31:0]           r_fx3_data;
    logic                  r_fx3_wr;
    logic                  r_pkt_end;

    logic                  w_stb;
    logic                  w_last;
    logic                  w_abort;

    assign w_stb   = (r_state == S_WRITE) && (r_burst != '0);
    assign w_last  = w_stb && (r_burst == ONE);
    assign w_abort = !i_out_path_enable;

    assign o_out_path_ready = i_rd_rdy && (r_state == S_IDLE)
                              && !i_out_path_enable;
    assign o_rd_stb               = w_stb;
    assign o_rd_act               = r_rd_act;
    assign o_out_path_busy        = r_busy;
    assign o_out_path_finished    = r_finished;
    assign o_out_dma_buf_finished = r_buf_fin;
    assign o_fx3_data             = r_fx3_data;
    assign o_fx3_wr               = r_fx3_wr;
    assign o_fx3_pkt_end          = r_pkt_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_remain   <= '0;
            r_burst    <= '0;
            r_short    <= 1'b0;
            r_rd_act   <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_buf_fin  <= 1'b0;
            r_fx3_data <= '0;
            r_fx3_wr   <= 1'b0;
            r_pkt_end  <= 1'b0;
        end else begin
            // A strobed word always lands on FX3, even on an abort edge
            r_buf_fin <= 1'b0;
            r_fx3_wr  <= w_stb;
            r_pkt_end <= w_last && r_short && i_out_path_enable;
            if (w_stb) begin
                r_fx3_data <= i_rd_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_out_path_enable && i_rd_rdy) begin
                        r_state  <= S_ACTIVATE;
                        r_rd_act <= 1'b1;
                        r_busy   <= 1'b1;
                        r_remain <= i_rd_size;
                    end
                end
                S_ACTIVATE: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_rd_act <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (r_remain == '0) begin
                        r_state    <= S_FINISH;
                        r_rd_act   <= 1'b0;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end else begin
                        r_state <= S_WAIT_BUF;
                    end
                end
                S_WAIT_BUF: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_rd_act <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (i_out_dma_buf_ready) begin
                        r_state <= S_WRITE;
                        r_short <= (r_remain < BUF_W);
                        r_burst <= (r_remain < BUF_W) ? r_remain : BUF_W;
                    end
                end
                S_WRITE: begin
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_rd_act <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_stb) begin
                        r_burst  <= r_burst - ONE;
                        r_remain <= r_remain - ONE;
                        if (w_last) begin
                            r_state   <= S_BUF_DONE;
                            r_buf_fin <= 1'b1;
                        end
                    end else begin
                        r_state   <= S_BUF_DONE;
                        r_buf_fin <= 1'b1;
                    end
                end
                S_BUF_DONE: begin
                    // Grant must drop before the next buffer may start
                    if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_rd_act <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (!i_out_dma_buf_ready) begin
                        if (r_remain == '0) begin
                            r_state    <= S_FINISH;
                            r_rd_act   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            r_state <= S_WAIT_BUF;
                        end
                    end
                end
                S_FINISH: begin
                    if (w_abort) begin
                        r_state    <= S_IDLE;
                        r_finished <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rd_act <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
